xup_debounce2: RTL and testbench

//   Input conditioner for slide-switch/push-button pins. Synchronizes WIDTH async

---
 rtl/xup_debounce2_pkg.sv | 20 ++
 rtl/xup_debounce2_if.sv | 17 +
 rtl/xup_debounce2_ch.sv | 134 +++++++++++++
 rtl/xup_debounce2.sv | 40 ++++
 tb/tb_xup_debounce2.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/xup_debounce2_pkg.sv
// Shared types and constants for the xup_debounce2 input conditioner.
//   db_state_t   per-channel debounce state
//   SYNC_STAGES  depth of the input synchronizer
//   cnt_width()  bits needed to hold a stability count of 0..n
package xup_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } db_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xup_debounce2_if.sv
// Pin-side bundle of the debouncer.
//   din   raw asynchronous pin levels (driven by master)
//   dout  debounced levels
//   rise  one-cycle pulse after dout goes 0->1
//   fall  one-cycle pulse after dout goes 1->0
// master: board/pin side, slave: the debouncer.
interface xup_debounce2_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (output din, input dout, input rise, input fall);
  modport slave  (input din, output dout, output rise, output fall);
endinterface

// File: rtl/xup_debounce2_ch.sv
// One debounce channel: 2-flop synchronizer, stability FSM with a saturating
// counter, and optional registered edge pulses.
//   clk, reset_n  clock and asynchronous active-low reset
//   din_i         raw pin level
//   dout_o        debounced level
//   rise_o/fall_o one-cycle pulse the cycle after dout_o changes
// Optional feature macro: XUP_DEBOUNCE_EDGE_EN (edge pulses built when defined,
// otherwise rise_o/fall_o are tied low).
//
// state     | meaning
// ----------+-------------------------------------------------
// STABLE_LO | accepted level 0, waiting for a high sample
// CHK_HI    | counting consecutive high samples
// STABLE_HI | accepted level 1, waiting for a low sample
// CHK_LO    | counting consecutive low samples
module xup_debounce_ch
  import xup_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Entering a CHK state already counts the first differing sample, so the
  // level is accepted once it has been seen STABLE_CYCLES+1 times in a row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // The accepted level is 1 while high is settled or while a drop is only
  // being qualified.
  always_comb begin
    dout_d = (state_d == STABLE_HI) || (state_d == CHK_LO);
  end

  assign dout_o = dout_q;

`ifdef XUP_DEBOUNCE_EDGE_EN
  logic dout_dly_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_dly_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      dout_dly_q <= dout_q;
      rise_q     <= dout_q & ~dout_dly_q;
      fall_q     <= ~dout_q & dout_dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/xup_debounce2.sv
// Input conditioner for slide-switch / push-button pins: WIDTH independent
// synchronize-and-debounce channels feeding clean levels to the gate stages.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      xup_debounce2_if slave: din in; dout, rise, fall out
// Optional feature macro: XUP_DEBOUNCE_EDGE_EN (registered rise/fall pulses;
// when undefined the rise/fall ports stay but read 0).
module xup_debounce2
  import xup_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset_n,
  xup_debounce2_if.slave  bus
);

  logic [WIDTH-1:0] dout_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    xup_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .din_i   (bus.din[i]),
      .dout_o  (dout_w[i]),
      .rise_o  (rise_w[i]),
      .fall_o  (fall_w[i])
    );
  end

  assign bus.dout = dout_w;
  assign bus.rise = rise_w;
  assign bus.fall = fall_w;

endmodule

// File: tb/tb_xup_debounce2.sv
// Bench for xup_debounce2 (WIDTH=2, STABLE_CYCLES=4). A run-length reference
// model predicts dout/rise/fall every cycle; directed scenarios add exact
// latency checks. Builds with or without XUP_DEBOUNCE_EDGE_EN.
module tb_xup_debounce2;

  localparam int W  = 2;
  localparam int SC = 4;
`ifdef XUP_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic chk_en  = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  xup_debounce2_if #(.WIDTH(W)) bus ();

  xup_debounce2 #(
    .WIDTH         (W),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a new level is accepted once the debouncer has observed
  // it on SC+1 consecutive edges, where the debouncer observes din as it was
  // two edges earlier. Edge pulses appear one cycle after the dout change.
  logic [W-1:0] seen2 = '0, seen1 = '0;
  logic [W-1:0] last_x = '0, m_dout = '0, m_rise = '0, m_fall = '0;
  logic [W-1:0] rose_pend = '0, fell_pend = '0;
  int           run [W] = '{default: 0};

  always @(posedge clk or negedge reset_n) begin
    logic [W-1:0] x;
    if (!reset_n) begin
      seen2 = '0; seen1 = '0; last_x = '0; m_dout = '0;
      m_rise = '0; m_fall = '0; rose_pend = '0; fell_pend = '0;
      run = '{default: 0};
    end else begin
      x = seen2;
      seen2 = seen1;
      seen1 = bus.din;
      m_rise = rose_pend;
      m_fall = fell_pend;
      rose_pend = '0;
      fell_pend = '0;
      for (int i = 0; i < W; i++) begin
        run[i] = (x[i] == last_x[i]) ? run[i] + 1 : 1;
        last_x[i] = x[i];
        if (x[i] != m_dout[i] && run[i] >= SC + 1) begin
          m_dout[i] = x[i];
          if (x[i]) rose_pend[i] = 1'b1;
          else      fell_pend[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_dout", 32'(bus.dout), 32'(m_dout));
      chk("model_rise", 32'(bus.rise), EDGE ? 32'(m_rise) : 32'd0);
      chk("model_fall", 32'(bus.fall), EDGE ? 32'(m_fall) : 32'd0);
    end
  end

  initial begin
    logic       dseen, eseen;
    logic [5:0] bounce;
    bus.din = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_rise", 32'(bus.rise), 32'd0);
    chk("rst_fall", 32'(bus.fall), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    // 1: single channel rise, exact latency and rise pulse
    bus.din = 2'b01;
    repeat (6) tick();
    chk("t1_dout_e6", 32'(bus.dout), 32'd0);
    tick();
    chk("t1_dout_e7", 32'(bus.dout), 32'h1);
    chk("t1_rise_e7", 32'(bus.rise), 32'd0);
    tick();
    chk("t1_rise_e8", 32'(bus.rise), EDGE ? 32'h1 : 32'd0);
    tick();
    chk("t1_rise_e9", 32'(bus.rise), 32'd0);

    // 2: short pulses on din[0] (3 and 4 cycles) never reach dout; 5 does
    bus.din = 2'b00;
    repeat (10) tick();
    for (int plen = 3; plen <= 5; plen++) begin
      dseen = 1'b0;
      eseen = 1'b0;
      bus.din = 2'b01;
      for (int k = 0; k < plen; k++) begin
        tick();
        dseen |= |bus.dout;
        eseen |= |bus.rise | |bus.fall;
      end
      bus.din = 2'b00;
      for (int k = 0; k < 12; k++) begin
        tick();
        dseen |= |bus.dout;
        eseen |= |bus.rise | |bus.fall;
      end
      chk($sformatf("t2_dout_p%0d", plen), 32'(dseen), (plen > SC) ? 32'd1 : 32'd0);
      chk($sformatf("t2_edge_p%0d", plen), 32'(eseen), (plen > SC && EDGE) ? 32'd1 : 32'd0);
    end

    // 3: bounce on din[1], then held high
    bounce = 6'b101101;
    for (int k = 0; k < 5; k++) begin
      bus.din = {bounce[5-k], 1'b0};
      tick();
    end
    bus.din = 2'b10;
    dseen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      dseen |= bus.dout[1];
    end
    chk("t3_dout_early", 32'(dseen), 32'd0);
    tick();
    chk("t3_dout_e7", 32'(bus.dout), 32'h2);

    // 4: reset mid-count discards the pending change
    bus.din = 2'b00;
    repeat (10) tick();
    bus.din = 2'b11;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("t4_dout_rst", 32'(bus.dout), 32'd0);
    tick();
    chk("t4_dout_rst2", 32'(bus.dout), 32'd0);
    reset_n = 1'b1;
    repeat (6) tick();
    chk("t4_dout_e6", 32'(bus.dout), 32'd0);
    tick();
    chk("t4_dout_e7", 32'(bus.dout), 32'h3);
    tick();
    chk("t4_rise_e8", 32'(bus.rise), EDGE ? 32'h3 : 32'd0);

    // 5: both channels drop together
    repeat (3) tick();
    bus.din = 2'b00;
    repeat (6) tick();
    chk("t5_dout_e6", 32'(bus.dout), 32'h3);
    tick();
    chk("t5_dout_e7", 32'(bus.dout), 32'd0);
    chk("t5_fall_e7", 32'(bus.fall), 32'd0);
    tick();
    chk("t5_fall_e8", 32'(bus.fall), EDGE ? 32'h3 : 32'd0);
    tick();
    chk("t5_fall_e9", 32'(bus.fall), 32'd0);

    // Random phase: model checker runs every cycle
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 15) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        reset_n = 1'b1;
      end
      bus.din = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 9)) tick();
    end
    repeat (12) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
